// File: rtl/axis_prbs_pkg.sv
// Shared PRBS32 definitions for the stream checker and the matching stream source.
package axis_prbs_pkg;

  typedef enum logic {
    SYNC   = 1'b0,
    LOCKED = 1'b1
  } checker_state_t;

  localparam logic [31:0] PRBS32_TAPS = 32'h80200003;

  // One word advance = 32 serial Fibonacci steps; the feedback bit enters at the LSB.
  function automatic logic [31:0] prbs_next(input logic [31:0] s, input logic [31:0] taps);
    logic [31:0] r;
    r = s;
    for (int i = 0; i < 32; i++) begin
      r = {r[30:0], ^(r & taps)};
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_prbs_checker.sv
// AXI-Stream PRBS32 sink: locks onto the incoming sequence and counts words and errors while locked.
// Optional macro AXIS_PRBS_CHECKER_STALL_EN gates saxis_tready with a free-running 8-bit LFSR.
module axis_prbs_checker
  import axis_prbs_pkg::*;
#(
  parameter int          DATA_BITS    = 32,
  parameter logic [31:0] TAPS         = PRBS32_TAPS,
  parameter int          LOCK_COUNT   = 4,
  parameter int          UNLOCK_COUNT = 8,
  parameter int          COUNT_BITS   = 32
) (
  input  logic                  clock,
  input  logic                  aresetn,
  input  logic [DATA_BITS-1:0]  saxis_tdata,
  input  logic                  saxis_tvalid,
  output logic                  saxis_tready,
  input  logic                  clear,
  output logic                  locked,
  output logic                  error_pulse,
  output logic [COUNT_BITS-1:0] word_count,
  output logic [COUNT_BITS-1:0] error_count
);

  if (DATA_BITS != 32 || LOCK_COUNT < 1 || LOCK_COUNT > 255 ||
      UNLOCK_COUNT < 1 || UNLOCK_COUNT > 255) begin : g_param_check
    $error("axis_prbs_checker: unsupported parameter value");
  end

  localparam logic [7:0]            LOCK_LAST   = 8'(LOCK_COUNT - 1);
  localparam logic [7:0]            UNLOCK_LAST = 8'(UNLOCK_COUNT - 1);
  localparam logic [COUNT_BITS-1:0] CNT_ONE     = COUNT_BITS'(1);

  checker_state_t        state_q, state_d;
  logic [7:0]            run_q, run_d;
  logic [DATA_BITS-1:0]  exp_q, exp_d;
  logic                  seeded_q, seeded_d;
  logic [COUNT_BITS-1:0] wc_q, wc_d;
  logic [COUNT_BITS-1:0] ec_q, ec_d;
  logic                  pulse_q, pulse_d;
  logic                  ready_q;
  logic                  beat;
  logic                  match;

  assign beat  = saxis_tvalid & saxis_tready;
  assign match = (saxis_tdata == exp_q);

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    exp_d    = exp_q;
    seeded_d = seeded_q;
    wc_d     = wc_q;
    ec_d     = ec_q;
    pulse_d  = 1'b0;
    if (clear) begin
      state_d  = SYNC;
      run_d    = '0;
      exp_d    = '0;
      seeded_d = 1'b0;
      wc_d     = '0;
      ec_d     = '0;
    end else if (beat) begin
      unique case (state_q)
        SYNC: begin
          // Separate seeded flag: an all-zero stream must still be able to lock.
          if (!seeded_q || !match) begin
            exp_d    = prbs_next(saxis_tdata, TAPS);
            run_d    = '0;
            seeded_d = 1'b1;
          end else begin
            exp_d = prbs_next(exp_q, TAPS);
            if (run_q == LOCK_LAST) begin
              state_d = LOCKED;
              run_d   = '0;
            end else begin
              run_d = run_q + 8'd1;
            end
          end
        end
        LOCKED: begin
          exp_d = prbs_next(exp_q, TAPS);
          if (wc_q != '1) wc_d = wc_q + CNT_ONE;
          if (!match) begin
            pulse_d = 1'b1;
            if (ec_q != '1) ec_d = ec_q + CNT_ONE;
            if (run_q == UNLOCK_LAST) begin
              state_d  = SYNC;
              run_d    = '0;
              seeded_d = 1'b0;
            end else begin
              run_d = run_q + 8'd1;
            end
          end else begin
            run_d = '0;
          end
        end
        default: state_d = SYNC;
      endcase
    end
  end

  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= SYNC;
      run_q    <= '0;
      exp_q    <= '0;
      seeded_q <= 1'b0;
      wc_q     <= '0;
      ec_q     <= '0;
      pulse_q  <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      exp_q    <= exp_d;
      seeded_q <= seeded_d;
      wc_q     <= wc_d;
      ec_q     <= ec_d;
      pulse_q  <= pulse_d;
      ready_q  <= 1'b1;
    end
  end

`ifdef AXIS_PRBS_CHECKER_STALL_EN
  logic [7:0] stall_lfsr_q;

  // x^8+x^6+x^5+x^4+1, maximal length, never reaches zero from the 8'h01 seed.
  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      stall_lfsr_q <= 8'h01;
    end else begin
      stall_lfsr_q <= {stall_lfsr_q[6:0],
                       stall_lfsr_q[7] ^ stall_lfsr_q[5] ^ stall_lfsr_q[4] ^ stall_lfsr_q[3]};
    end
  end

  assign saxis_tready = ready_q & stall_lfsr_q[0];
`else
  assign saxis_tready = ready_q;
`endif

  assign locked      = (state_q == LOCKED);
  assign error_pulse = pulse_q;
  assign word_count  = wc_q;
  assign error_count = ec_q;

endmodule

// File: tb/tb_axis_prbs_checker.sv
// Self-checking bench for axis_prbs_checker: directed table, corner sequences, randomized traffic vs a bit-stream model.
module tb_axis_prbs_checker;

  localparam int LOCK_N   = 4;
  localparam int UNLOCK_N = 8;

  logic        clock = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] saxis_tdata = '0;
  logic        saxis_tvalid = 1'b0;
  logic        saxis_tready;
  logic        clear = 1'b0;
  logic        locked;
  logic        error_pulse;
  logic [31:0] word_count;
  logic [31:0] error_count;

  axis_prbs_checker dut (
    .clock       (clock),
    .aresetn     (aresetn),
    .saxis_tdata (saxis_tdata),
    .saxis_tvalid(saxis_tvalid),
    .saxis_tready(saxis_tready),
    .clear       (clear),
    .locked      (locked),
    .error_pulse (error_pulse),
    .word_count  (word_count),
    .error_count (error_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int low_cnt = 0;
  logic rdy_armed = 1'b0;

  // Reference model state, expressed directly in terms of the behavioural rules.
  bit          m_locked, m_seeded, m_pulse;
  int          m_run;
  logic [31:0] m_exp, m_wc, m_ec;
  logic [31:0] src;

  // Next word computed from the bit-serial recurrence x[n] = x[n-32]^x[n-22]^x[n-2]^x[n-1].
  function automatic logic [31:0] model_next(input logic [31:0] w);
    bit x[64];
    logic [31:0] r;
    for (int k = 0; k < 32; k++) x[31-k] = w[k];
    for (int n = 32; n < 64; n++) x[n] = x[n-32] ^ x[n-22] ^ x[n-2] ^ x[n-1];
    for (int k = 0; k < 32; k++) r[k] = x[63-k];
    return r;
  endfunction

  function automatic void model_reset();
    m_locked = 0; m_seeded = 0; m_pulse = 0; m_run = 0;
    m_exp = '0; m_wc = '0; m_ec = '0;
  endfunction

  function automatic void model_beat(input logic [31:0] d);
    if (!m_locked) begin
      if (!m_seeded || d != m_exp) begin
        m_exp = model_next(d); m_run = 0; m_seeded = 1;
      end else begin
        m_exp = model_next(m_exp); m_run++;
        if (m_run == LOCK_N) begin m_locked = 1; m_run = 0; end
      end
    end else begin
      if (m_wc != 32'hFFFF_FFFF) m_wc++;
      if (d != m_exp) begin
        if (m_ec != 32'hFFFF_FFFF) m_ec++;
        m_pulse = 1; m_run++;
        if (m_run == UNLOCK_N) begin m_locked = 0; m_seeded = 0; m_run = 0; end
      end else begin
        m_run = 0;
      end
      m_exp = model_next(m_exp);
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive at edge+1, let the edge happen, compare against the model at edge+1.
  task automatic tick(input logic v, input logic [31:0] d, input logic clr, output logic acc);
    saxis_tvalid = v;
    saxis_tdata  = d;
    clear        = clr;
    acc = v && saxis_tready;
    @(posedge clock); #1;
    m_pulse = 0;
    if (clr) model_reset();
    else if (acc) model_beat(d);
    chk("locked", locked, m_locked);
    chk("error_pulse", error_pulse, m_pulse);
    chk("word_count", word_count, m_wc);
    chk("error_count", error_count, m_ec);
    if (!saxis_tready) low_cnt++;
`ifndef AXIS_PRBS_CHECKER_STALL_EN
    if (rdy_armed) chk("tready_high", saxis_tready, 1'b1);
`endif
    saxis_tvalid = 1'b0;
    clear        = 1'b0;
  endtask

  task automatic send(input logic [31:0] mask, input int gaps, input logic clr);
    logic acc;
    int tries;
    for (int g = 0; g < gaps; g++) tick(1'b0, $urandom, 1'b0, acc);
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 64) begin
      tick(1'b1, src ^ mask, clr, acc);
      tries++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: beat not accepted within %0d cycles", tries);
    end
    src = model_next(src);
  endtask

  typedef struct {
    logic [31:0] mask;
    logic        exp_locked;
    logic        exp_pulse;
    int          exp_wc;
    int          exp_ec;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic acc;

    tbl[0] = '{32'h0, 1'b0, 1'b0, 0, 0};
    tbl[1] = '{32'h0, 1'b0, 1'b0, 0, 0};
    tbl[2] = '{32'h0, 1'b0, 1'b0, 0, 0};
    tbl[3] = '{32'h0, 1'b0, 1'b0, 0, 0};
    tbl[4] = '{32'h0, 1'b1, 1'b0, 0, 0};
    tbl[5] = '{32'h0, 1'b1, 1'b0, 1, 0};
    tbl[6] = '{32'h0, 1'b1, 1'b0, 2, 0};
    tbl[7] = '{32'h1, 1'b1, 1'b1, 3, 1};
    tbl[8] = '{32'h0, 1'b1, 1'b0, 4, 1};
    tbl[9] = '{32'h0, 1'b1, 1'b0, 5, 1};

    model_reset();
    src = 32'h0000_0001;

    @(posedge clock); #1;
    chk("rst_tready", saxis_tready, 1'b0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_pulse", error_pulse, 1'b0);
    chk("rst_wc", word_count, 32'd0);
    chk("rst_ec", error_count, 32'd0);
    aresetn   = 1'b1;
    rdy_armed = 1'b1;

    // Lock-up and a single corrupted word.
    for (int i = 0; i < 10; i++) begin
      send(tbl[i].mask, 0, 1'b0);
      chk($sformatf("tbl%0d_locked", i), locked, tbl[i].exp_locked);
      chk($sformatf("tbl%0d_pulse", i), error_pulse, tbl[i].exp_pulse);
      chk($sformatf("tbl%0d_wc", i), word_count, 32'(tbl[i].exp_wc));
      chk($sformatf("tbl%0d_ec", i), error_count, 32'(tbl[i].exp_ec));
    end

    for (int i = 0; i < 90; i++) send(32'h0, 0, 1'b0);
    chk("clean100_wc", word_count, 32'd95);
    chk("clean100_ec", error_count, 32'd1);

    // Eight consecutive bad words force SYNC on the eighth.
    for (int i = 0; i < 8; i++) begin
      send(32'h1, 0, 1'b0);
      if (i == 6) chk("burst7_locked", locked, 1'b1);
    end
    chk("burst8_locked", locked, 1'b0);
    chk("burst8_ec", error_count, 32'd9);
    chk("burst8_wc", word_count, 32'd103);
    for (int i = 0; i < 5; i++) begin
      send(32'h0, 0, 1'b0);
      if (i == 3) chk("relock4_locked", locked, 1'b0);
    end
    chk("relock5_locked", locked, 1'b1);
    chk("relock5_wc", word_count, 32'd103);

    // clear with a simultaneous beat: beat ignored, everything back to zero.
    send(32'h0, 0, 1'b1);
    chk("clr1_locked", locked, 1'b0);
    chk("clr1_wc", word_count, 32'd0);
    for (int i = 0; i < 5; i++) send(32'h0, 0, 1'b0);
    chk("clr1_relock", locked, 1'b1);
    for (int i = 0; i < 50; i++) send(32'h0, 0, 1'b0);
    chk("pre_clr2_wc", word_count, 32'd50);
    send(32'h0, 0, 1'b1);
    chk("clr2_locked", locked, 1'b0);
    chk("clr2_wc", word_count, 32'd0);
    chk("clr2_ec", error_count, 32'd0);
    for (int i = 0; i < 5; i++) send(32'h0, 0, 1'b0);
    chk("clr2_relock", locked, 1'b1);

    // 1000 clean beats with random idle gaps.
    tick(1'b0, 32'h0, 1'b1, acc);
    for (int i = 0; i < 1000; i++) send(32'h0, $urandom_range(0, 2), 1'b0);
    chk("gaps_wc", word_count, 32'd995);
    chk("gaps_ec", error_count, 32'd0);

    // Random corruption with periodic bursts long enough to unlock.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] m;
      m = '0;
      if ((i % 100) >= 40 && (i % 100) < 52) m = 32'h8000_0000;
      else if ($urandom_range(0, 15) == 0) m = 32'h1 << $urandom_range(0, 31);
      send(m, $urandom_range(0, 2), ($urandom_range(0, 199) == 0));
    end

    // Asynchronous reset mid-stream.
    #2;
    aresetn = 1'b0;
    #1;
    chk("arst_locked", locked, 1'b0);
    chk("arst_wc", word_count, 32'd0);
    chk("arst_ec", error_count, 32'd0);
    chk("arst_pulse", error_pulse, 1'b0);
    chk("arst_tready", saxis_tready, 1'b0);
    @(posedge clock); #1;
    aresetn = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) send(32'h0, 0, 1'b0);
    chk("arst_relock", locked, 1'b1);
    chk("arst_wc_restart", word_count, 32'd5);
    chk("arst_ec_restart", error_count, 32'd0);

`ifdef AXIS_PRBS_CHECKER_STALL_EN
    chk("tready_toggles", (low_cnt > 0), 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
